// File: rtl/multicycle_controller.sv
// Purpose : Moore FSM sequencing a shared-memory multicycle RV32I datapath (lw, sw, R, I-ALU, beq, jal).
// Latency : R/I=4, beq=3, jal=4, sw=4, lw=5 cycles with mem_ready=1; each memory wait cycle adds one.
// Backpr. : FETCH, MEMREAD and MEMWRITE hold until mem_ready=1; mem_ready is ignored in every other state.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   Op, Zero            opcode from the instruction register; ALU zero flag
//   mem_ready           the memory finishes the current access this cycle
//   PCWrite .. ALUOp    datapath enables and mux selects, decoded from state
//   ImmSrc              immediate format, decoded from Op only
//   illegal, instret    sticky trap flag; retired-instruction count
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALUOp,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    state_t state, state_next;

    // Raw state decodes; gated by rst below so nothing toggles during reset.
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
        end else if (retire) begin
            // Wraps naturally modulo 2^INSTRET_W.
            instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 computed while the instruction is read; both land only when memory answers.
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm precomputed into ALUOut as the beq/jal target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXEC_R;
                    OP_IALU:      state_next = S_EXEC_I;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole access, not just the completing cycle.
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd;
                // the following ALUWB writes rd and retires the jal.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    always_comb begin
        case (Op)
            OP_LW, OP_IALU: imm_src = 2'b00;
            OP_SW:          imm_src = 2'b01;
            OP_BEQ:         imm_src = 2'b10;
            OP_JAL:         imm_src = 2'b11;
            default:        imm_src = 2'b00;
        endcase
    end

    assign PCWrite   = rst & (pc_update | (branch & Zero));
    assign AdrSrc    = rst & adr_src;
    assign MemWrite  = rst & mem_write;
    assign IRWrite   = rst & ir_write;
    assign RegWrite  = rst & reg_write;
    assign ResultSrc = rst ? result_src : 2'b00;
    assign ALUSrcA   = rst ? alu_src_a  : 2'b00;
    assign ALUSrcB   = rst ? alu_src_b  : 2'b00;
    assign ALUOp     = rst ? alu_op     : 2'b00;
    assign ImmSrc    = rst ? imm_src    : 2'b00;
    assign illegal   = rst & (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : Directed bench for multicycle_controller (INSTRET_W=4 so the counter wrap is reachable).
// Latency : inputs driven after the falling edge, outputs sampled 1 time unit later.
// Backpr. : mem_ready stalls driven explicitly per step.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
    logic       illegal;
    logic [3:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller #(.INSTRET_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (Op),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUOp     (ALUOp),
        .illegal   (illegal),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    logic [12:0] outs;
    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

    localparam logic [12:0] V_FETCH    = 13'b1_0_0_1_0_10_00_10_00;
    localparam logic [12:0] V_FETCH_W  = 13'b0_0_0_0_0_10_00_10_00;
    localparam logic [12:0] V_DECODE   = 13'b0_0_0_0_0_00_01_01_00;
    localparam logic [12:0] V_MEMADR   = 13'b0_0_0_0_0_00_10_01_00;
    localparam logic [12:0] V_MEMREAD  = 13'b0_1_0_0_0_00_00_00_00;
    localparam logic [12:0] V_MEMWB    = 13'b0_0_0_0_1_01_00_00_00;
    localparam logic [12:0] V_MEMWRITE = 13'b0_1_1_0_0_00_00_00_00;
    localparam logic [12:0] V_EXEC_R   = 13'b0_0_0_0_0_00_10_00_10;
    localparam logic [12:0] V_EXEC_I   = 13'b0_0_0_0_0_00_10_01_10;
    localparam logic [12:0] V_ALUWB    = 13'b0_0_0_0_1_00_00_00_00;
    localparam logic [12:0] V_BEQ_T    = 13'b1_0_0_0_0_00_10_00_01;
    localparam logic [12:0] V_BEQ_N    = 13'b0_0_0_0_0_00_10_00_01;
    localparam logic [12:0] V_JAL      = 13'b1_0_0_0_0_00_01_10_00;
    localparam logic [12:0] V_ZERO     = 13'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the current state's outputs, advance.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [12:0] exp);
        mem_ready = mr;
        Zero      = z;
        #1;
        chk(tag, 16'(outs), 16'(exp));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        Op        = 7'b0100011;
        Zero      = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_outs", 16'(outs), 16'(V_ZERO));
        chk("reset_immsrc", 16'(ImmSrc), 16'd0);
        chk("reset_instret", 16'(instret), 16'd0);
        chk("reset_illegal", 16'(illegal), 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // R-type, no stalls
        Op = 7'b0110011;
        cyc("r_fetch", 1'b1, 1'b0, V_FETCH);
        chk("r_immsrc", 16'(ImmSrc), 16'd0);
        cyc("r_decode", 1'b1, 1'b0, V_DECODE);
        cyc("r_exec", 1'b1, 1'b0, V_EXEC_R);
        chk("r_instret_pre", 16'(instret), 16'd0);
        cyc("r_aluwb", 1'b1, 1'b0, V_ALUWB);
        chk("r_instret", 16'(instret), 16'd1);

        // lw, two wait cycles in MEMREAD (mem_ready ignored in DECODE/MEMADR)
        Op = 7'b0000011;
        cyc("lw_fetch", 1'b1, 1'b0, V_FETCH);
        cyc("lw_decode", 1'b0, 1'b0, V_DECODE);
        cyc("lw_memadr", 1'b0, 1'b0, V_MEMADR);
        cyc("lw_rd_w0", 1'b0, 1'b0, V_MEMREAD);
        cyc("lw_rd_w1", 1'b0, 1'b0, V_MEMREAD);
        cyc("lw_rd_ok", 1'b1, 1'b0, V_MEMREAD);
        cyc("lw_memwb", 1'b0, 1'b0, V_MEMWB);
        chk("lw_instret", 16'(instret), 16'd2);

        // sw, one wait cycle in MEMWRITE
        Op = 7'b0100011;
        cyc("sw_fetch", 1'b1, 1'b0, V_FETCH);
        chk("sw_immsrc", 16'(ImmSrc), 16'd1);
        cyc("sw_decode", 1'b1, 1'b0, V_DECODE);
        cyc("sw_memadr", 1'b1, 1'b0, V_MEMADR);
        cyc("sw_wr_w0", 1'b0, 1'b0, V_MEMWRITE);
        chk("sw_instret_wait", 16'(instret), 16'd2);
        cyc("sw_wr_ok", 1'b1, 1'b0, V_MEMWRITE);
        chk("sw_instret", 16'(instret), 16'd3);

        // beq taken then not taken
        Op = 7'b1100011;
        cyc("beq1_fetch", 1'b1, 1'b0, V_FETCH);
        chk("beq_immsrc", 16'(ImmSrc), 16'd2);
        cyc("beq1_decode", 1'b1, 1'b1, V_DECODE);
        cyc("beq1_taken", 1'b1, 1'b1, V_BEQ_T);
        cyc("beq2_fetch", 1'b1, 1'b0, V_FETCH);
        cyc("beq2_decode", 1'b1, 1'b0, V_DECODE);
        cyc("beq2_nottaken", 1'b1, 1'b0, V_BEQ_N);
        chk("beq_instret", 16'(instret), 16'd5);

        // I-type with one fetch stall
        Op = 7'b0010011;
        cyc("i_fetch_w", 1'b0, 1'b0, V_FETCH_W);
        cyc("i_fetch", 1'b1, 1'b0, V_FETCH);
        cyc("i_decode", 1'b1, 1'b0, V_DECODE);
        cyc("i_exec", 1'b1, 1'b0, V_EXEC_I);
        cyc("i_aluwb", 1'b1, 1'b0, V_ALUWB);
        chk("i_instret", 16'(instret), 16'd6);

        // jal retires in its ALUWB, not in JAL
        Op = 7'b1101111;
        cyc("jal_fetch", 1'b1, 1'b0, V_FETCH);
        chk("jal_immsrc", 16'(ImmSrc), 16'd3);
        cyc("jal_decode", 1'b1, 1'b0, V_DECODE);
        cyc("jal_jal", 1'b1, 1'b0, V_JAL);
        chk("jal_instret_mid", 16'(instret), 16'd6);
        cyc("jal_aluwb", 1'b1, 1'b0, V_ALUWB);
        chk("jal_instret", 16'(instret), 16'd7);

        // reset asserted mid-MEMWRITE
        Op = 7'b0100011;
        cyc("abort_fetch", 1'b1, 1'b0, V_FETCH);
        cyc("abort_decode", 1'b1, 1'b0, V_DECODE);
        cyc("abort_memadr", 1'b1, 1'b0, V_MEMADR);
        mem_ready = 1'b0;
        #1;
        chk("abort_memwrite", 16'(outs), 16'(V_MEMWRITE));
        #1;
        rst = 1'b0;
        #1;
        chk("abort_outs_async", 16'(outs), 16'(V_ZERO));
        chk("abort_instret_async", 16'(instret), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        Op  = 7'b0110011;
        cyc("abort_restart_fetch", 1'b1, 1'b0, V_FETCH);
        cyc("abort_restart_decode", 1'b1, 1'b0, V_DECODE);
        cyc("abort_restart_exec", 1'b1, 1'b0, V_EXEC_R);
        cyc("abort_restart_aluwb", 1'b1, 1'b0, V_ALUWB);
        chk("abort_instret_1", 16'(instret), 16'd1);

        // 15 more R-types: counter 1 -> ... -> 15 -> 0
        for (int i = 2; i <= 16; i++) begin
            mem_ready = 1'b1;
            repeat (4) @(negedge clk);
            #1;
            chk($sformatf("wrap_instret_%0d", i), 16'(instret), 16'(i % 16));
        end

        // unsupported opcode traps and stays there until reset
        Op = 7'b0000000;
        cyc("trap_fetch", 1'b1, 1'b0, V_FETCH);
        cyc("trap_decode", 1'b1, 1'b0, V_DECODE);
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            Zero      = 1'b1;
            #1;
            chk($sformatf("trap_outs_%0d", i), 16'(outs), 16'(V_ZERO));
            chk($sformatf("trap_illegal_%0d", i), 16'(illegal), 16'd1);
            @(posedge clk);
            @(negedge clk);
        end
        chk("trap_instret", 16'(instret), 16'd0);
        rst = 1'b0;
        #1;
        chk("trap_cleared", 16'(illegal), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        Op  = 7'b0110011;
        cyc("post_trap_fetch", 1'b1, 1'b0, V_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
